// File: rtl/step_pattern_keypad.sv
`default_nettype none
// ============================================================================
// Module   : step_pattern_keypad
// Purpose  : Debounces NSTEPS step pushbuttons and toggles one pattern bit per
//            debounced press. The pattern drives the sequencer's kbd_in.
//            picoVersat can overwrite the pattern (wr_en/wr_data). It collects
//            accumulated press events through a valid/ack handshake
//            (evt_valid/evt_mask/rd_ack).
// Ports    : clk, rst (async, active-high)
//            btn_in[NSTEPS]  raw buttons, 1 = pressed
//            wr_en, wr_data  pattern overwrite strobe/value
//            rd_ack          event consumed strobe
//            pattern_out     current step pattern
//            evt_valid       unacknowledged press pending
//            evt_mask        OR of steps pressed since last ack
//            clr_btn/evt_clr only when SEQ_CLEAR_BTN_EN is defined
// Options  : SEQ_CLEAR_BTN_EN - adds a debounced clear button that zeroes the
//            pattern and raises evt_clr
// Revision : 1.0 - initial release
// ============================================================================
module step_pattern_keypad #(
  parameter int NSTEPS     = 8,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTEPS-1:0] btn_in,
  input  logic              wr_en,
  input  logic [NSTEPS-1:0] wr_data,
  input  logic              rd_ack,
`ifdef SEQ_CLEAR_BTN_EN
  input  logic              clr_btn,
  output logic              evt_clr,
`endif
  output logic [NSTEPS-1:0] pattern_out,
  output logic              evt_valid,
  output logic [NSTEPS-1:0] evt_mask
);

  // The clear button, when present, rides as the top bit through the same
  // synchronizer/debounce path as the step buttons.
`ifdef SEQ_CLEAR_BTN_EN
  localparam int c_nb = NSTEPS + 1;
`else
  localparam int c_nb = NSTEPS;
`endif
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEB_CYCLES - 1);

  logic [c_nb-1:0] w_raw;
  logic [c_nb-1:0] r_sync1;
  logic [c_nb-1:0] r_sync2;
  logic [c_nb-1:0] w_press;

`ifdef SEQ_CLEAR_BTN_EN
  assign w_raw = {clr_btn, btn_in};
`else
  assign w_raw = btn_in;
`endif

  // Two-flop synchronizer for every raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce. The counter runs only while the synchronized level
  // disagrees with the accepted level. Any agreement (a bounce) restarts it.
  for (genvar i = 0; i < c_nb; i++) begin : g_deb
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_stable <= 1'b0;
        r_cnt    <= '0;
      end else if (r_sync2[i] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_stable <= r_sync2[i];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // Press pulse coincides with the edge at which stable rises.
    assign w_press[i] = r_sync2[i] && !r_stable && (r_cnt == c_cnt_max);
  end

  // Effective events after priority resolution: a write discards everything
  // in its cycle, and a clear press discards simultaneous step presses.
  logic              w_clr_press;
  logic [NSTEPS-1:0] w_step_press;
  logic              w_any;

`ifdef SEQ_CLEAR_BTN_EN
  assign w_clr_press  = w_press[NSTEPS] && !wr_en;
  assign w_step_press = (wr_en || w_press[NSTEPS]) ? '0 : w_press[NSTEPS-1:0];
`else
  assign w_clr_press  = 1'b0;
  assign w_step_press = wr_en ? '0 : w_press;
`endif
  assign w_any = (|w_step_press) || w_clr_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pattern_out <= '0;
    else if (wr_en)
      pattern_out <= wr_data;
    else if (w_clr_press)
      pattern_out <= '0;
    else
      pattern_out <= pattern_out ^ w_step_press;
  end

  // Event handshake FSM
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NSTEPS-1:0] w_mask_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      evt_mask <= '0;
    end else begin
      r_state  <= w_state_nxt;
      evt_mask <= w_mask_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = evt_mask;
    case (r_state)
      IDLE: begin
        w_mask_nxt = w_step_press;
        if (w_any) w_state_nxt = PEND;
      end
      PEND: begin
        if (rd_ack) begin
          // Presses arriving with the ack start the next event, never lost.
          w_mask_nxt = w_step_press;
          if (!w_any) w_state_nxt = IDLE;
        end else begin
          w_mask_nxt = evt_mask | w_step_press;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign evt_valid = (r_state == PEND);

`ifdef SEQ_CLEAR_BTN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      evt_clr <= 1'b0;
    else if (r_state == PEND && !rd_ack)
      evt_clr <= evt_clr | w_clr_press;
    else
      evt_clr <= w_clr_press;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_step_pattern_keypad.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_pattern_keypad
// Purpose  : Self-checking bench for step_pattern_keypad (DEB_CYCLES=4,
//            NSTEPS=8). Directed scenarios followed by random button activity.
//            A window-based reference model checks every cycle: a level is
//            accepted once DEB consecutive synchronized samples agree.
// Options  : SEQ_CLEAR_BTN_EN - also exercises clr_btn/evt_clr
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_pattern_keypad;

  localparam int N   = 8;
  localparam int DEB = 4;
`ifdef SEQ_CLEAR_BTN_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic         wr_en = 1'b0;
  logic [N-1:0] wr_data = '0;
  logic         rd_ack = 1'b0;
  logic [N-1:0] pattern_out;
  logic         evt_valid;
  logic [N-1:0] evt_mask;
`ifdef SEQ_CLEAR_BTN_EN
  logic         clr_btn = 1'b0;
  logic         evt_clr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  step_pattern_keypad #(.NSTEPS(N), .DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_ack      (rd_ack),
`ifdef SEQ_CLEAR_BTN_EN
    .clr_btn     (clr_btn),
    .evt_clr     (evt_clr),
`endif
    .pattern_out (pattern_out),
    .evt_valid   (evt_valid),
    .evt_mask    (evt_mask)
  );

  always #5 clk = ~clk;

  // Reference model state. m_hist[j] holds the raw sample taken j+1 edges
  // before the upcoming edge. The 2-flop delay means the window that decides
  // an edge is m_hist[1..DEB].
  logic [NB-1:0] m_hist [DEB+1];
  logic [NB-1:0] m_stable;
  logic [N-1:0]  m_pat;
  logic [N-1:0]  m_mask;
  logic          m_valid;
  logic          m_clr;

  task automatic model_reset();
    for (int j = 0; j <= DEB; j++) m_hist[j] = '0;
    m_stable = '0;
    m_pat    = '0;
    m_mask   = '0;
    m_valid  = 1'b0;
    m_clr    = 1'b0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] all1, all0, press;
    logic [N-1:0]  step;
    logic          clr;
    all1 = '1;
    all0 = '1;
    for (int j = 1; j <= DEB; j++) begin
      all1 &= m_hist[j];
      all0 &= ~m_hist[j];
    end
    press    = ~m_stable & all1;
    m_stable = (m_stable & ~all0) | all1;
    for (int j = DEB; j >= 1; j--) m_hist[j] = m_hist[j-1];
`ifdef SEQ_CLEAR_BTN_EN
    m_hist[0] = {clr_btn, btn_in};
    clr = press[N];
`else
    m_hist[0] = btn_in;
    clr = 1'b0;
`endif
    step = press[N-1:0];
    if (wr_en) begin
      step = '0;
      clr  = 1'b0;
    end
    if (clr) step = '0;
    m_pat = wr_en ? wr_data : (clr ? '0 : (m_pat ^ step));
    if (m_valid && !rd_ack) begin
      m_mask |= step;
      m_clr  |= clr;
    end else begin
      m_mask  = step;
      m_clr   = clr;
      m_valid = (step != 0) || clr;
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("pattern", pattern_out, m_pat);
    chk("valid", {7'd0, evt_valid}, {7'd0, m_valid});
    chk("mask", evt_mask, m_mask);
`ifdef SEQ_CLEAR_BTN_EN
    chk("evt_clr", {7'd0, evt_clr}, {7'd0, m_clr});
`endif
  endtask

  // One clock edge with the given inputs, then a model step and a full check.
  task automatic tick(input logic [N-1:0] b, input logic w, input logic [N-1:0] wd,
                      input logic a);
    btn_in  = b;
    wr_en   = w;
    wr_data = wd;
    rd_ack  = a;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic ticks(input int n, input logic [N-1:0] b);
    for (int i = 0; i < n; i++) tick(b, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_pattern", pattern_out, 8'h00);
    chk("rst_valid", {7'd0, evt_valid}, 8'h00);
    chk("rst_mask", evt_mask, 8'h00);
    for (int i = 0; i < cycles; i++) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pattern", pattern_out, 8'h00);
    chk("reset_valid", {7'd0, evt_valid}, 8'h00);
    chk("reset_mask", evt_mask, 8'h00);
    rst = 1'b0;
    ticks(2, 8'h00);

    // 1: btn 3 press, toggle on the sixth edge with the button high.
    ticks(5, 8'h08);
    chk("t1_before", pattern_out, 8'h00);
    tick(8'h08, 1'b0, '0, 1'b0);
    chk("t1_pattern", pattern_out, 8'h08);
    chk("t1_valid", {7'd0, evt_valid}, 8'h01);
    chk("t1_mask", evt_mask, 8'h08);
    ticks(4, 8'h08);
    ticks(10, 8'h00);
    chk("t1_release", pattern_out, 8'h08);
    chk("t1_rel_mask", evt_mask, 8'h08);

    // 2: bounce on btn 0 is rejected.
    ticks(3, 8'h01);
    ticks(10, 8'h00);
    chk("t2_pattern", pattern_out, 8'h08);
    chk("t2_mask", evt_mask, 8'h08);

    // 3: write on the same edge as a btn 0 press wins.
    ticks(5, 8'h01);
    tick(8'h01, 1'b1, 8'hA5, 1'b0);
    chk("t3_pattern", pattern_out, 8'hA5);
    chk("t3_mask", evt_mask, 8'h08);
    ticks(10, 8'h00);

    // 4: ack coincident with a btn 5 press starts a new event.
    ticks(5, 8'h20);
    tick(8'h20, 1'b0, '0, 1'b1);
    chk("t4_mask", evt_mask, 8'h20);
    chk("t4_valid", {7'd0, evt_valid}, 8'h01);
    ticks(10, 8'h00);
    tick(8'h00, 1'b0, '0, 1'b1);
    chk("t4_ack_valid", {7'd0, evt_valid}, 8'h00);
    chk("t4_ack_mask", evt_mask, 8'h00);

    // 5: simultaneous presses on btn 1 and btn 6.
    tick(8'h00, 1'b1, 8'h42, 1'b0);
    ticks(6, 8'h42);
    chk("t5_pattern", pattern_out, 8'h00);
    chk("t5_mask", evt_mask, 8'h42);
    ticks(10, 8'h00);

    // 6: reset two cycles into a btn 2 debounce, button held throughout.
    tick(8'h00, 1'b1, 8'hFF, 1'b0);
    ticks(2, 8'h04);
    do_reset(2);
    ticks(5, 8'h04);
    chk("t6_before", pattern_out, 8'h00);
    tick(8'h04, 1'b0, '0, 1'b0);
    chk("t6_pattern", pattern_out, 8'h04);
    ticks(10, 8'h00);

`ifdef SEQ_CLEAR_BTN_EN
    tick(8'h00, 1'b1, 8'hFF, 1'b1);
    clr_btn = 1'b1;
    ticks(6, 8'h00);
    chk("clr_pattern", pattern_out, 8'h00);
    chk("clr_evt", {7'd0, evt_clr}, 8'h01);
    chk("clr_valid", {7'd0, evt_valid}, 8'h01);
    clr_btn = 1'b0;
    ticks(10, 8'h00);
`endif

    // Random phase: slowly changing buttons with occasional strobes.
    begin
      logic [N-1:0] b;
      b = '0;
      for (int i = 0; i < 600; i++) begin
        for (int k = 0; k < N; k++)
          if ($urandom_range(5) == 0) b[k] = ~b[k];
`ifdef SEQ_CLEAR_BTN_EN
        if ($urandom_range(7) == 0) clr_btn = ~clr_btn;
`endif
        if (i == 300) do_reset(1);
        tick(b, ($urandom_range(15) == 0), N'($urandom), ($urandom_range(3) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
